dbg_uart_arbiter: RTL
=====================

Name: dbg_uart_arbiter

Overview:
- Shares the single debug UART transmitter between two byte sources.
  - CPU writes to the debug UART address, buffered in a small FIFO.
  - A hardware trace source using a hold-until-ack handshake.
- Sits between the peripheral decode/write logic and the uart_tx instance, driving its enable/data inputs and watching its busy output.
- Arbitration is round-robin per byte; one byte is in flight at a time.

Parameters:
- FIFO_DEPTH, 4, CPU byte FIFO entries. Power of two, ≥2.
- GUARD_CYCLES, 3, max cycles to wait for tx_busy to rise after a launch before returning to IDLE.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cpu_wr_en  input  1  single-cycle push of cpu_wr_data.
- cpu_wr_data  input  8  CPU byte.
- cpu_full  output  1  FIFO holds FIFO_DEPTH entries.
- cpu_level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- trc_req  input  1  trace byte pending; held with trc_data stable until trc_ack.
- trc_data  input  8  trace byte.
- trc_ack  output  1  one-cycle acceptance of trace byte.
- tx_start  output  1  one-cycle pulse to uart_tx enable.
- tx_data  output  8  byte to uart_tx; registered, stable from launch until next launch.
- tx_busy  input  1  uart_tx busy.
- busy  output  1  pending work: cpu_level≠0 or trc_req or FSM≠IDLE or tx_busy. Used for the UART status read.
- overflow  output  1  sticky: a CPU byte was dropped.
- clr_overflow  input  1  clears overflow.

Behaviour:
Reset (asynchronous, rst=1):
- FIFO empty: cpu_level=0, cpu_full=0.
- tx_start=0, trc_ack=0, tx_data=8'h00, overflow=0, FSM=IDLE.
- last_grant=TRC, so the CPU wins the first tie.
- Reset mid-transfer discards FIFO contents and any in-flight handshake. No tx_start is emitted during or on the cycle after reset release.

FIFO:
- Circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
- Push when cpu_wr_en=1:
  - Accepted if not full.
  - Also accepted if full and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
- Simultaneous push and pop: level unchanged.
- clr_overflow and a same-cycle drop: overflow stays set (set wins).

FSM states IDLE, LAUNCH, WAIT_HI, WAIT_LO:
- IDLE:
  - If tx_busy=0 and any source is pending (cpu_level≠0 or trc_req), grant one source.
  - Both pending: grant the source not equal to last_grant. Otherwise grant the one pending.
  - On grant: register tx_data (FIFO head, or trc_data), update last_grant, go to LAUNCH.
  - If tx_busy=1, stay in IDLE.
- LAUNCH (exactly 1 cycle):
  - tx_start=1.
  - If CPU granted: pop the FIFO this cycle. If trace granted: trc_ack=1 this cycle.
  - Go to WAIT_HI; load guard counter with GUARD_CYCLES.
- WAIT_HI:
  - tx_busy=1 → WAIT_LO.
  - Else decrement the guard; at 0 → IDLE (no retry, byte considered sent).
- WAIT_LO: tx_busy=0 → IDLE.

Timing and invariants:
- Minimum latency from a push into an empty, idle system to tx_start is 2 cycles: push at edge N, grant at N+1, tx_start high during cycle N+1..N+2.
- Minimum spacing between tx_start pulses is 4 cycles.
- trc_req dropping before ack: the request is withdrawn. If dropped after grant but during LAUNCH, the byte is still sent (data already registered).
- tx_start and trc_ack are never asserted outside LAUNCH.

Test Plan:
- Reset → all outputs at reset values; assert rst during WAIT_LO with 2 bytes queued → level=0, tx_start stays 0 after release.
- Push 0x41, 0x42 with tx_busy model (busy 1 cycle after start, 10 cycles long) → tx_start twice, tx_data 0x41 then 0x42, level returns 0.
- CPU FIFO holding 3 bytes and trc_req=1 with trc_data=0xA5 from idle → grant order CPU, TRC, CPU, CPU; trc_ack exactly once, in the second LAUNCH.
- Fill 4 entries with tx_busy held 1, push a 5th → dropped, overflow=1, cpu_full=1; pulse clr_overflow → overflow=0.
- FIFO full, push in the same cycle as LAUNCH pop → accepted, level stays 4, no overflow; pointer wrap verified over 10 bytes in order.
- tx_busy tied 0 → after launch, FSM returns to IDLE 3 cycles after WAIT_HI entry; next byte launched; no hang.

Source files
------------

// File: rtl/dbg_uart_arbiter.sv
// rtl/dbg_uart_arbiter.sv - round-robin per-byte sharing of the debug UART transmitter
// between a buffered CPU byte stream and a hold-until-ack trace source.
module dbg_uart_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int GUARD_CYCLES = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpu_wr_en,
    input  logic [7:0]                    cpu_wr_data,
    output logic                          cpu_full,
    output logic [$clog2(FIFO_DEPTH):0]   cpu_level,
    input  logic                          trc_req,
    input  logic [7:0]                    trc_data,
    output logic                          trc_ack,
    output logic                          tx_start,
    output logic [7:0]                    tx_data,
    input  logic                          tx_busy,
    output logic                          busy,
    output logic                          overflow,
    input  logic                          clr_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [GW-1:0] guard;
    logic          grant_cpu;
    logic          last_cpu;
    logic          cpu_pend;
    logic          pop;
    logic          push;
    logic          drop;

    assign cpu_full = (cpu_level == LW'(FIFO_DEPTH));
    assign cpu_pend = (cpu_level != '0);
    assign pop      = (state == LAUNCH) && grant_cpu;
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign push     = cpu_wr_en && (!cpu_full || pop);
    assign drop     = cpu_wr_en && !push;
    assign busy     = cpu_pend || trc_req || (state != IDLE) || tx_busy;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cpu_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cpu_level <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                cpu_level <= cpu_level + LW'(1);
            end else if (pop && !push) begin
                cpu_level <= cpu_level - LW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx_start  <= 1'b0;
            trc_ack   <= 1'b0;
            tx_data   <= 8'h00;
            grant_cpu <= 1'b0;
            last_cpu  <= 1'b0;
            guard     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!tx_busy && (cpu_pend || trc_req)) begin
                        // CPU wins when alone or when the trace source had the previous turn.
                        if (cpu_pend && (!trc_req || !last_cpu)) begin
                            grant_cpu <= 1'b1;
                            last_cpu  <= 1'b1;
                            tx_data   <= mem[rd_ptr];
                        end else begin
                            grant_cpu <= 1'b0;
                            last_cpu  <= 1'b0;
                            tx_data   <= trc_data;
                            trc_ack   <= 1'b1;
                        end
                        tx_start <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tx_start <= 1'b0;
                    trc_ack  <= 1'b0;
                    guard    <= GW'(GUARD_CYCLES);
                    state    <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        state <= WAIT_LO;
                    end else if (guard <= GW'(1)) begin
                        state <= IDLE;
                    end else begin
                        guard <= guard - GW'(1);
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
